// File: rtl/ascon_sequencer.sv
// Control sequencer for an Ascon-style encryption datapath: walks init, associated
// data, plaintext blocks and finalisation, strobing the datapath one round per cycle.
module ascon_sequencer #(
   parameter int unsigned NB_BLOCKS = 3
) (
   input  logic       clock_i,
   input  logic       resetb_i,
   input  logic       start_i,
   input  logic       abort_i,
   input  logic       data_valid_i,
   output logic       data_ready_o,
   output logic       state_load_o,
   output logic       perm_en_o,
   output logic [3:0] round_o,
   output logic       data_xor_o,
   output logic       key_xor_begin_o,
   output logic       key_xor_end_o,
   output logic       domain_sep_o,
   output logic       cipher_valid_o,
   output logic       tag_valid_o,
   output logic [1:0] blk_o,
   output logic       busy_o,
   output logic       done_o
);

   typedef enum logic [2:0] {IDLE, INIT, AD, PT_WAIT, PT, FINAL, DONE} state_t;

   localparam logic [3:0] LAST_RND = 4'd11;
   localparam logic [1:0] LAST_BLK = 2'(NB_BLOCKS - 1);

   state_t     state, state_nxt;
   logic [3:0] rnd, rnd_nxt;
   logic [1:0] blk, blk_nxt;

   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         state <= IDLE;
         rnd   <= '0;
         blk   <= '0;
      end else begin
         state <= state_nxt;
         rnd   <= rnd_nxt;
         blk   <= blk_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      rnd_nxt         = rnd;
      blk_nxt         = blk;
      data_ready_o    = 1'b0;
      state_load_o    = 1'b0;
      perm_en_o       = 1'b0;
      data_xor_o      = 1'b0;
      key_xor_begin_o = 1'b0;
      key_xor_end_o   = 1'b0;
      domain_sep_o    = 1'b0;
      cipher_valid_o  = 1'b0;
      tag_valid_o     = 1'b0;
      done_o          = 1'b0;
      unique case (state)
         IDLE: begin
            // start_i reaches state_load_o combinationally, so mask it while in reset
            if (start_i && resetb_i) begin
               state_load_o = 1'b1;
               state_nxt    = INIT;
               rnd_nxt      = '0;
               blk_nxt      = '0;
            end
         end
         INIT: begin
            perm_en_o = 1'b1;
            if (rnd == LAST_RND) begin
               key_xor_end_o = 1'b1;
               state_nxt     = AD;
               rnd_nxt       = 4'd6;
            end else begin
               rnd_nxt = rnd + 4'd1;
            end
         end
         AD: begin
            perm_en_o  = 1'b1;
            data_xor_o = (rnd == 4'd6);
            if (rnd == LAST_RND) begin
               domain_sep_o = 1'b1;
               state_nxt    = PT_WAIT;
               rnd_nxt      = '0;
            end else begin
               rnd_nxt = rnd + 4'd1;
            end
         end
         PT_WAIT: begin
            data_ready_o = 1'b1;
            if (data_valid_i) begin
               data_xor_o     = 1'b1;
               cipher_valid_o = 1'b1;
               blk_nxt        = blk + 2'd1;
               if (blk == LAST_BLK) begin
                  key_xor_begin_o = 1'b1;
                  state_nxt       = FINAL;
                  rnd_nxt         = '0;
               end else begin
                  state_nxt = PT;
                  rnd_nxt   = 4'd6;
               end
            end
         end
         PT: begin
            perm_en_o = 1'b1;
            if (rnd == LAST_RND) begin
               state_nxt = PT_WAIT;
               rnd_nxt   = '0;
            end else begin
               rnd_nxt = rnd + 4'd1;
            end
         end
         FINAL: begin
            perm_en_o = 1'b1;
            if (rnd == LAST_RND) begin
               key_xor_end_o = 1'b1;
               tag_valid_o   = 1'b1;
               state_nxt     = DONE;
               rnd_nxt       = '0;
            end else begin
               rnd_nxt = rnd + 4'd1;
            end
         end
         DONE: begin
            done_o    = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            rnd_nxt   = '0;
            blk_nxt   = '0;
         end
      endcase

      // abort silences every strobe of the current cycle and clears the counters
      if (abort_i) begin
         state_nxt       = IDLE;
         rnd_nxt         = '0;
         blk_nxt         = '0;
         data_ready_o    = 1'b0;
         state_load_o    = 1'b0;
         perm_en_o       = 1'b0;
         data_xor_o      = 1'b0;
         key_xor_begin_o = 1'b0;
         key_xor_end_o   = 1'b0;
         domain_sep_o    = 1'b0;
         cipher_valid_o  = 1'b0;
         tag_valid_o     = 1'b0;
         done_o          = 1'b0;
      end
   end

   assign round_o = perm_en_o ? rnd : '0;
   assign blk_o   = blk;
   assign busy_o  = (state != IDLE);

endmodule

// File: tb/tb_ascon_sequencer.sv
// Bench for ascon_sequencer: two instances (3 blocks and 1 block) checked every cycle
// against a message-level model, plus directed timing checks with literal expectations.
module tb_ascon_sequencer;

   logic clk = 1'b0;
   logic resetb, start, abort, valid;
   logic [1:0] rdy, ld, pe, dx, kb, ke, ds, cv, tv, by, dn;
   logic [3:0] rnd_o [2];
   logic [1:0] bk [2];

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   ascon_sequencer #(.NB_BLOCKS(3)) u_nb3 (
      .clock_i(clk), .resetb_i(resetb), .start_i(start), .abort_i(abort),
      .data_valid_i(valid), .data_ready_o(rdy[0]), .state_load_o(ld[0]),
      .perm_en_o(pe[0]), .round_o(rnd_o[0]), .data_xor_o(dx[0]),
      .key_xor_begin_o(kb[0]), .key_xor_end_o(ke[0]), .domain_sep_o(ds[0]),
      .cipher_valid_o(cv[0]), .tag_valid_o(tv[0]), .blk_o(bk[0]),
      .busy_o(by[0]), .done_o(dn[0]));

   ascon_sequencer #(.NB_BLOCKS(1)) u_nb1 (
      .clock_i(clk), .resetb_i(resetb), .start_i(start), .abort_i(abort),
      .data_valid_i(valid), .data_ready_o(rdy[1]), .state_load_o(ld[1]),
      .perm_en_o(pe[1]), .round_o(rnd_o[1]), .data_xor_o(dx[1]),
      .key_xor_begin_o(kb[1]), .key_xor_end_o(ke[1]), .domain_sep_o(ds[1]),
      .cipher_valid_o(cv[1]), .tag_valid_o(tv[1]), .blk_o(bk[1]),
      .busy_o(by[1]), .done_o(dn[1]));

   function automatic logic [16:0] act_vec(input int d);
      return {rdy[d], ld[d], pe[d], rnd_o[d], dx[d], kb[d], ke[d], ds[d],
              cv[d], tv[d], bk[d], by[d], dn[d]};
   endfunction

   task automatic check_int(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Message-level model: phases of a message and the round range of each permutation.
   localparam int P_IDLE = 0, P_RUN = 1, P_WAIT = 2, P_DONE = 3;
   localparam int S_INIT = 0, S_AD = 1, S_PT = 2, S_FIN = 3;
   int nbv [2] = '{3, 1};
   int ph [2] = '{P_IDLE, P_IDLE};
   int sg [2] = '{0, 0};
   int mr [2] = '{0, 0};
   int mb [2] = '{0, 0};

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         logic e_rdy, e_ld, e_pe, e_dx, e_kb, e_ke, e_ds, e_cv, e_tv, e_by, e_dn;
         logic [3:0] e_rnd;
         logic [16:0] exp_v;
         {e_rdy, e_ld, e_pe, e_dx, e_kb, e_ke, e_ds, e_cv, e_tv, e_by, e_dn} = '0;
         e_rnd = '0;
         if (!resetb) begin
            exp_v = '0;
            ph[d] = P_IDLE; mb[d] = 0; mr[d] = 0;
         end else begin
            e_by = (ph[d] != P_IDLE);
            if (!abort) begin
               case (ph[d])
                  P_IDLE: e_ld = start;
                  P_RUN: begin
                     e_pe  = 1'b1;
                     e_rnd = 4'(mr[d]);
                     if (sg[d] == S_AD && mr[d] == 6) e_dx = 1'b1;
                     if (mr[d] == 11) begin
                        e_ke = (sg[d] == S_INIT || sg[d] == S_FIN);
                        e_ds = (sg[d] == S_AD);
                        e_tv = (sg[d] == S_FIN);
                     end
                  end
                  P_WAIT: begin
                     e_rdy = 1'b1;
                     e_dx  = valid;
                     e_cv  = valid;
                     e_kb  = valid && (mb[d] == nbv[d] - 1);
                  end
                  default: e_dn = 1'b1;
               endcase
            end
            exp_v = {e_rdy, e_ld, e_pe, e_rnd, e_dx, e_kb, e_ke, e_ds, e_cv, e_tv,
                     2'(mb[d]), e_by, e_dn};
            if (abort) begin
               ph[d] = P_IDLE; mb[d] = 0; mr[d] = 0;
            end else begin
               case (ph[d])
                  P_IDLE: if (start) begin ph[d] = P_RUN; sg[d] = S_INIT; mr[d] = 0; mb[d] = 0; end
                  P_RUN: begin
                     if (mr[d] < 11) mr[d]++;
                     else if (sg[d] == S_INIT) begin sg[d] = S_AD; mr[d] = 6; end
                     else if (sg[d] == S_FIN) ph[d] = P_DONE;
                     else ph[d] = P_WAIT;
                  end
                  P_WAIT: if (valid) begin
                     mb[d]++;
                     ph[d] = P_RUN;
                     if (mb[d] == nbv[d]) begin sg[d] = S_FIN; mr[d] = 0; end
                     else begin sg[d] = S_PT; mr[d] = 6; end
                  end
                  default: ph[d] = P_IDLE;
               endcase
            end
         end
         vectors++;
         if (act_vec(d) !== exp_v) begin
            miscompares++;
            $display("FAIL dut%0d outputs: got %h, expected %h at %0t", d, act_vec(d), exp_v, $time);
         end
      end
   end

   // One message on both instances; valid follows nb3's ready with an optional stall.
   task automatic run_msg(input int stall_wait, input int stall_len, input bit spurious,
                          output int e0, output int e1, output int ncv, output int ntv,
                          output int nrdy, output int nkb1, output int blk1);
      int waits = 0, stalled = 0;
      e0 = 0; e1 = -1; ncv = 0; ntv = 0; nrdy = 0; nkb1 = 0; blk1 = -1;
      @(posedge clk); #1 start = 1'b1; valid = 1'b1;
      @(posedge clk); #1 start = spurious;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk);
         e0++;
         #1;
         start = spurious && (e0 < 30);
         valid = 1'b1;
         if (rdy[0]) begin
            nrdy++;
            if (waits == stall_wait && stalled < stall_len) begin
               valid = 1'b0; stalled++;
            end else waits++;
         end
         #1;
         ncv += int'(cv[0]); ntv += int'(tv[0]); nkb1 += int'(kb[1]);
         if (dn[1]) begin e1 = e0; blk1 = int'(bk[1]); end
         if (dn[0]) break;
      end
      if (!dn[0]) begin
         vectors++; miscompares++;
         $display("FAIL done timeout: got no done_o, expected done_o within 300 edges");
      end
      start = 1'b0; valid = 1'b0;
      repeat (3) @(posedge clk);
   endtask

   initial begin
      int e0, e1, ncv, ntv, nrdy, nkb1, blk1;
      resetb = 1'b0; start = 1'b0; abort = 1'b0; valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 check_int("reset outputs nb3", int'(act_vec(0)), 0);
      check_int("reset outputs nb1", int'(act_vec(1)), 0);
      resetb = 1'b1;

      run_msg(-1, 0, 1'b0, e0, e1, ncv, ntv, nrdy, nkb1, blk1);
      check_int("nominal done edge nb3", e0, 45);
      check_int("nominal cipher_valid count", ncv, 3);
      check_int("nominal tag_valid count", ntv, 1);
      check_int("nb1 done edge", e1, 31);
      check_int("nb1 key_xor_begin count", nkb1, 1);
      check_int("nb1 blk at done", blk1, 1);

      run_msg(1, 10, 1'b0, e0, e1, ncv, ntv, nrdy, nkb1, blk1);
      check_int("stall done edge", e0, 55);
      check_int("stall ready cycles", nrdy, 13);

      run_msg(-1, 0, 1'b1, e0, e1, ncv, ntv, nrdy, nkb1, blk1);
      check_int("spurious start done edge", e0, 45);
      check_int("spurious start cipher count", ncv, 3);

      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (5) @(posedge clk);
      #1 check_int("init round before abort", int'(rnd_o[0]), 5);
      abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      check_int("abort busy", int'(by[0]), 0);
      check_int("abort blk", int'(bk[0]), 0);
      run_msg(-1, 0, 1'b0, e0, e1, ncv, ntv, nrdy, nkb1, blk1);
      check_int("post-abort done edge", e0, 45);

      @(posedge clk); #1 start = 1'b1; valid = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (40) @(posedge clk);
      #1 check_int("final round before reset", int'(rnd_o[0]), 7);
      #2 resetb = 1'b0;
      #1 check_int("async reset outputs nb3", int'(act_vec(0)), 0);
      check_int("async reset outputs nb1", int'(act_vec(1)), 0);
      repeat (3) @(posedge clk);
      #1 resetb = 1'b1;
      repeat (3) @(posedge clk);
      #1 check_int("idle ignores valid busy", int'(by[0]), 0);
      check_int("idle ignores valid ready", int'(rdy[0]), 0);
      resetb = 1'b0;
      @(posedge clk); #1 resetb = 1'b1; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      check_int("first start after reset", int'(by[0]), 1);
      check_int("first start round", int'(rnd_o[0]), 0);
      abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;

      for (int i = 0; i < 1500; i++) begin
         @(posedge clk); #1;
         start = ($urandom % 8) == 0;
         abort = ($urandom % 64) == 0;
         valid = ($urandom % 3) != 0;
      end
      @(posedge clk); #1 start = 1'b0; abort = 1'b0; valid = 1'b0;
      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ascon_sequencer.md
ASCON_SEQUENCER -- requirements
Module: ascon_sequencer

Interface
REQ-001 SHALL provide parameter NB_BLOCKS, default 3, number of plaintext blocks per message (legal 1..3).
REQ-002 SHALL provide clock_i  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL provide resetb_i  input  1  asynchronous active-low reset.
REQ-004 SHALL provide start_i  input  1  request to process one message; sampled only in IDLE.
REQ-005 SHALL provide abort_i  input  1  synchronous return to IDLE from any state.
REQ-006 SHALL provide data_valid_i  input  1  plaintext block present on datapath input.
REQ-007 SHALL provide data_ready_o  output  1  sequencer waiting for a plaintext block.
REQ-008 SHALL provide state_load_o  output  1  load initial state (key, nonce, IV) into state register.
REQ-009 SHALL provide perm_en_o  output  1  apply one permutation round this cycle.
REQ-010 SHALL provide round_o  output  4  round index fed to the round-constant logic.
REQ-011 SHALL provide data_xor_o  output  1  XOR data block into rate.
REQ-012 SHALL provide key_xor_begin_o  output  1  XOR key into capacity before the first round.
REQ-013 SHALL provide key_xor_end_o  output  1  XOR key into capacity after the last round.
REQ-014 SHALL provide domain_sep_o  output  1  XOR domain-separation bit into LSB.
REQ-015 SHALL provide cipher_valid_o  output  1  ciphertext block valid this cycle.
REQ-016 SHALL provide tag_valid_o  output  1  tag valid this cycle.
REQ-017 SHALL provide blk_o  output  2  index of current plaintext block.
REQ-018 SHALL provide busy_o  output  1  high in every state except IDLE.
REQ-019 SHALL provide done_o  output  1  one-cycle end-of-message pulse.

Function
REQ-020 SHALL implement states IDLE, INIT, AD, PT_WAIT, PT, FINAL, DONE, plus internal 4-bit round counter rnd and 2-bit block counter blk.
REQ-021 IDLE: all strobes 0; on start_i=1, state_load_o=1 that cycle, then INIT with rnd=0, blk=0.
REQ-022 INIT: perm_en_o=1 and round_o=rnd each cycle, rnd+1 per cycle; at rnd=11, key_xor_end_o=1, then AD with rnd=6.
REQ-023 AD: perm_en_o=1, rounds 6..11; data_xor_o=1 at rnd=6; domain_sep_o=1 at rnd=11, then PT_WAIT.
REQ-024 PT_WAIT: data_ready_o=1, perm_en_o=0; data_valid_i=0 -> hold indefinitely.
REQ-025 PT_WAIT with data_valid_i=1: data_xor_o=1 and cipher_valid_o=1 combinationally in the same cycle; blk increments.
REQ-026 Accepted block with blk<NB_BLOCKS-1 -> PT with rnd=6.
REQ-027 Accepted block with blk=NB_BLOCKS-1 -> FINAL with rnd=0; key_xor_begin_o=1 in the accepting cycle.
REQ-028 PT: perm_en_o=1, rounds 6..11, then PT_WAIT.
REQ-029 FINAL: perm_en_o=1, rounds 0..11; at rnd=11, key_xor_end_o=1 and tag_valid_o=1, then DONE.
REQ-030 DONE: done_o=1 for exactly one cycle, then IDLE; blk_o holds NB_BLOCKS until the next start.
REQ-031 round_o SHALL be 0 when perm_en_o=0.
REQ-032 rnd and blk SHALL NOT wrap: rnd never exceeds 11, and blk never exceeds NB_BLOCKS.
REQ-033 start_i outside IDLE SHALL be ignored; start_i held high through DONE re-launches only after one IDLE cycle.
REQ-034 abort_i=1 SHALL win over every other input: next state IDLE, rnd=0, blk=0; no strobes asserted in that cycle except busy_o.
REQ-035 With data_valid_i held high and NB_BLOCKS=3, DONE SHALL be entered 45 rising edges after the edge sampling start_i.

Reset
REQ-036 resetb_i=0 SHALL immediately force IDLE, rnd=0, blk=0, and all outputs 0, regardless of clock, including mid-permutation.
REQ-037 After resetb_i deasserts, the first start_i SHALL be accepted on the first rising edge.

Verification
REQ-038 Nominal: NB_BLOCKS=3, start_i pulse, data_valid_i=1 -> rounds 0..11, 6..11, (6..11)x2, 0..11; cipher_valid_o x3; tag_valid_o once; done_o 45 edges after start.
REQ-039 Stall: data_valid_i=0 for 10 cycles at the second PT_WAIT -> data_ready_o high for 10 cycles, perm_en_o=0, done_o delayed by exactly 10 cycles.
REQ-040 Boundary: NB_BLOCKS=1 -> a single PT_WAIT acceptance goes straight to FINAL with key_xor_begin_o=1, blk_o=1 at done.
REQ-041 Abort: abort_i at INIT rnd=5 -> IDLE next cycle, busy_o=0, blk_o=0; a new start runs a full nominal sequence.
REQ-042 Reset mid-FINAL: resetb_i low at rnd=7 -> all outputs 0 asynchronously; after release, IDLE ignores data_valid_i=1.
REQ-043 Spurious start: start_i=1 throughout AD and PT -> no restart; sequence identical to REQ-038.
